// File: rtl/rotary_decoder_if.sv
// Encoder pins and decoded event outputs of rotary_decoder.
// The master drives the raw encoder lines and the slave (the decoder) reports the decoded events.
interface rotary_decoder_if #(
  parameter int POS_WIDTH = 8
);
  logic                 rot_a;
  logic                 rot_b;
  logic                 rot_press;
  logic                 step;
  logic                 dir;
  logic [POS_WIDTH-1:0] position;
  logic                 press_pulse;

  modport master (
    output rot_a, rot_b, rot_press,
    input  step, dir, position, press_pulse
  );

  modport slave (
    input  rot_a, rot_b, rot_press,
    output step, dir, position, press_pulse
  );
endinterface

// File: rtl/rotary_decoder.sv
// Quadrature rotary encoder decoder with push switch.
// Each input passes through a synchronizer and a debouncer; a detent is counted when a full 4-transition sequence returns to rest.
module rotary_decoder #(
  parameter int DEBOUNCE_CYCLES = 5000,
  parameter int POS_WIDTH       = 8
) (
  input logic             clk,
  input logic             rst,
  rotary_decoder_if.slave bus
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Bit order {press, b, a}; encoder rests at a=b=1, switch rests released.
  localparam logic [2:0]       IDLE_LVL = 3'b011;

  logic [2:0]           w_raw;
  logic [2:0]           r_sync_p0;
  logic [2:0]           r_sync_p1;
  logic [2:0]           r_deb_p2;
  logic [CNT_W-1:0]     r_cnt [3];

  logic [1:0]           w_pair;
  logic [1:0]           r_pair_prev;
  logic signed [1:0]    w_delta;
  logic signed [3:0]    w_delta4;
  logic signed [3:0]    w_acc_next;
  logic signed [3:0]    r_acc;
  logic                 w_illegal;
  logic                 w_enter_detent;

  logic                 r_step;
  logic                 r_dir;
  logic [POS_WIDTH-1:0] r_pos;
  logic                 r_press_prev;
  logic                 r_press_pulse;

  function automatic logic signed [1:0] quad_delta(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: quad_delta = 2'sd1;
      4'b10_11, 4'b00_10, 4'b01_00, 4'b11_01: quad_delta = -2'sd1;
      default:                                quad_delta = 2'sd0;
    endcase
  endfunction

  assign w_raw = {bus.rot_press, bus.rot_b, bus.rot_a};

  // Stage p0/p1: two-flop synchronizers; stage p2: per-input debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= IDLE_LVL;
      r_sync_p1 <= IDLE_LVL;
      r_deb_p2  <= IDLE_LVL;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync_p0 <= w_raw;
      r_sync_p1 <= r_sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (r_sync_p1[i] == r_deb_p2[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb_p2[i] <= r_sync_p1[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_pair         = r_deb_p2[1:0];
  assign w_delta        = quad_delta(r_pair_prev, w_pair);
  assign w_delta4       = w_delta;
  assign w_illegal      = ((r_pair_prev ^ w_pair) == 2'b11);
  assign w_acc_next     = w_illegal ? 4'sd0 : (r_acc + w_delta4);
  assign w_enter_detent = (w_pair == 2'b11) && (r_pair_prev != 2'b11);

  // Stage p3: quadrature accumulation, detent detection and press edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pair_prev   <= 2'b11;
      r_acc         <= '0;
      r_step        <= 1'b0;
      r_dir         <= 1'b0;
      r_pos         <= '0;
      r_press_prev  <= 1'b0;
      r_press_pulse <= 1'b0;
    end else begin
      r_pair_prev   <= w_pair;
      r_step        <= 1'b0;
      r_press_prev  <= r_deb_p2[2];
      r_press_pulse <= r_deb_p2[2] & ~r_press_prev;
      if (w_enter_detent) begin
        // Only a complete one-way quarter sequence counts; anything else is dropped here.
        r_acc <= '0;
        if (w_acc_next == 4'sd4) begin
          r_step <= 1'b1;
          r_dir  <= 1'b1;
          r_pos  <= r_pos + POS_WIDTH'(1);
        end else if (w_acc_next == -4'sd4) begin
          r_step <= 1'b1;
          r_dir  <= 1'b0;
          r_pos  <= r_pos - POS_WIDTH'(1);
        end
      end else begin
        r_acc <= w_acc_next;
      end
    end
  end

  assign bus.step        = r_step;
  assign bus.dir         = r_dir;
  assign bus.position    = r_pos;
  assign bus.press_pulse = r_press_pulse;
endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with DEBOUNCE_CYCLES=4, POS_WIDTH=8.
// Raw edge to output pulse latency is 2 (sync) + 4 (debounce) + 1 = 7 cycles.
module tb_rotary_decoder;
  localparam int DEB     = 4;
  localparam int PW      = 8;
  localparam int LATENCY = 2 + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   step_cnt  = 0;
  int   press_cnt = 0;
  int   step_cyc  = 0;
  int   press_cyc = 0;

  rotary_decoder_if #(.POS_WIDTH(PW)) bus ();

  rotary_decoder #(.DEBOUNCE_CYCLES(DEB), .POS_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.step === 1'b1) begin
      step_cnt = step_cnt + 1;
      step_cyc = cyc;
    end
    if (bus.press_pulse === 1'b1) begin
      press_cnt = press_cnt + 1;
      press_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic [1:0] p);
    bus.rot_b = p[1];
    bus.rot_a = p[0];
  endtask

  task automatic hold_pair(input logic [1:0] p);
    set_pair(p);
    tick(10);
  endtask

  task automatic bounce_to(input logic [1:0] p);
    set_pair(p);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      bus.rot_a = ~bus.rot_a;
    end
    tick(1);
    bus.rot_a = p[0];
    tick(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_pair(2'b11);
    bus.rot_press = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pair(2'b11);
    bus.rot_press = 1'b0;
    tick(3);
    total++; if (bus.step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", bus.step); end
    total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b want=0", bus.dir); end
    total++; if (bus.position !== 8'd0) begin bad++; $display("FAIL reset_position got=%0d want=0", bus.position); end
    total++; if (bus.press_pulse !== 1'b0) begin bad++; $display("FAIL reset_press got=%b want=0", bus.press_pulse); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_cw_detent();
    int s0;
    s0 = step_cnt;
    hold_pair(2'b10); hold_pair(2'b00); hold_pair(2'b01); hold_pair(2'b11);
    total++; if (step_cnt - s0 != 1) begin bad++; $display("FAIL cw_steps got=%0d want=1", step_cnt - s0); end
    total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL cw_dir got=%b want=1", bus.dir); end
    total++; if (bus.position !== 8'd1) begin bad++; $display("FAIL cw_position got=%0d want=1", bus.position); end
  endtask

  task automatic test_ccw_wrap();
    int s0;
    do_reset();
    s0 = step_cnt;
    hold_pair(2'b01); hold_pair(2'b00); hold_pair(2'b10); hold_pair(2'b11);
    total++; if (step_cnt - s0 != 1) begin bad++; $display("FAIL ccw_steps got=%0d want=1", step_cnt - s0); end
    total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL ccw_dir got=%b want=0", bus.dir); end
    total++; if (bus.position !== 8'd255) begin bad++; $display("FAIL ccw_position got=%0d want=255", bus.position); end
  endtask

  task automatic test_bounce();
    int s0;
    int mid;
    s0 = step_cnt;
    bounce_to(2'b10); bounce_to(2'b00); bounce_to(2'b01);
    mid = step_cnt - s0;
    bounce_to(2'b11);
    total++; if (mid != 0) begin bad++; $display("FAIL bounce_early_steps got=%0d want=0", mid); end
    total++; if (step_cnt - s0 != 1) begin bad++; $display("FAIL bounce_steps got=%0d want=1", step_cnt - s0); end
    total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL bounce_dir got=%b want=1", bus.dir); end
    total++; if (bus.position !== 8'd0) begin bad++; $display("FAIL bounce_position got=%0d want=0", bus.position); end
  endtask

  task automatic test_half_turn();
    int s0;
    s0 = step_cnt;
    hold_pair(2'b10); hold_pair(2'b00); hold_pair(2'b10); hold_pair(2'b11);
    total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL half_steps got=%0d want=0", step_cnt - s0); end
    total++; if (bus.position !== 8'd0) begin bad++; $display("FAIL half_position got=%0d want=0", bus.position); end
  endtask

  task automatic test_illegal();
    int s0;
    s0 = step_cnt;
    hold_pair(2'b00); hold_pair(2'b11);
    total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL illegal_steps got=%0d want=0", step_cnt - s0); end
    s0 = step_cnt;
    hold_pair(2'b10); hold_pair(2'b00); hold_pair(2'b01); hold_pair(2'b11);
    total++; if (step_cnt - s0 != 1) begin bad++; $display("FAIL illegal_follow_steps got=%0d want=1", step_cnt - s0); end
    total++; if (bus.position !== 8'd1) begin bad++; $display("FAIL illegal_follow_position got=%0d want=1", bus.position); end
  endtask

  task automatic test_press();
    int p0;
    int rise_cyc;
    p0 = press_cnt;
    bus.rot_press = 1'b1;
    rise_cyc = cyc;
    tick(20);
    bus.rot_press = 1'b0;
    tick(15);
    total++; if (press_cnt - p0 != 1) begin bad++; $display("FAIL press_pulses got=%0d want=1", press_cnt - p0); end
    total++; if (press_cyc - rise_cyc != LATENCY) begin bad++; $display("FAIL press_latency got=%0d want=%0d", press_cyc - rise_cyc, LATENCY); end
  endtask

  task automatic test_reset_mid_rotation();
    int s0;
    do_reset();
    s0 = step_cnt;
    hold_pair(2'b10); hold_pair(2'b00);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    hold_pair(2'b01); hold_pair(2'b11);
    tick(5);
    total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL midreset_steps got=%0d want=0", step_cnt - s0); end
    total++; if (bus.position !== 8'd0) begin bad++; $display("FAIL midreset_position got=%0d want=0", bus.position); end
  endtask

  task automatic test_simultaneous();
    int s0;
    int p0;
    s0 = step_cnt;
    p0 = press_cnt;
    hold_pair(2'b10); hold_pair(2'b00); hold_pair(2'b01);
    set_pair(2'b11);
    bus.rot_press = 1'b1;
    tick(12);
    bus.rot_press = 1'b0;
    tick(12);
    total++; if (step_cnt - s0 != 1) begin bad++; $display("FAIL simul_steps got=%0d want=1", step_cnt - s0); end
    total++; if (press_cnt - p0 != 1) begin bad++; $display("FAIL simul_pulses got=%0d want=1", press_cnt - p0); end
    total++; if (step_cyc != press_cyc) begin bad++; $display("FAIL simul_same_cycle got=%0d want=%0d", press_cyc, step_cyc); end
    total++; if (bus.position !== 8'd1) begin bad++; $display("FAIL simul_position got=%0d want=1", bus.position); end
  endtask

  initial begin
    bus.rot_a     = 1'b1;
    bus.rot_b     = 1'b1;
    bus.rot_press = 1'b0;
    test_reset();
    test_cw_detent();
    test_ccw_wrap();
    test_bounce();
    test_half_turn();
    test_illegal();
    test_press();
    test_reset_mid_rotation();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rotary_decoder.md
ROTARY_DECODER -- requirements
Module: rotary_decoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 5000, giving the consecutive stable cycles needed to accept a new input level (minimum 2).
REQ-002 The block SHALL have parameter POS_WIDTH, default 8, giving the width of the position counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  system clock, all state on rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: rot_a  input  1  raw encoder channel A, asynchronous, bouncing.
REQ-007 Port: rot_b  input  1  raw encoder channel B, asynchronous, bouncing.
REQ-008 Port: rot_press  input  1  raw encoder push switch, asynchronous, active-high, bouncing.
REQ-009 Port: step  output  1  one-cycle pulse per completed detent.
REQ-010 Port: dir  output  1  direction of the last step; 1 = clockwise, 0 = counter-clockwise.
REQ-011 Port: position  output  POS_WIDTH  detent count, modulo 2^POS_WIDTH.
REQ-012 Port: press_pulse  output  1  one-cycle pulse per debounced press.

Function
REQ-013 Each raw input SHALL pass through its own two-flop synchronizer before any other logic.
REQ-014 Each synchronized input SHALL have an independent debouncer: a counter that clears whenever the synchronized level equals the debounced level, and increments otherwise.
REQ-015 The debounced level SHALL take the synchronized level on the edge where the counter reaches DEBOUNCE_CYCLES-1; the counter SHALL clear on that edge.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-017 The quadrature logic SHALL register the previous debounced pair {b,a} and compare it every cycle with the current pair.
REQ-018 The clockwise sequence SHALL be {b,a} = 11 -> 10 -> 00 -> 01 -> 11; each forward transition SHALL add 1 to a 4-bit signed accumulator.
REQ-019 Each reverse transition in that sequence SHALL subtract 1 from the accumulator.
REQ-020 A transition in which both bits change SHALL be illegal: no step is emitted and the accumulator is cleared to 0.
REQ-021 No change in the pair SHALL leave the accumulator unchanged.
REQ-022 Rest state 11 is the detent. On a transition into 11, step SHALL assert on the next edge if the updated accumulator equals +4 (dir=1) or -4 (dir=0); the accumulator SHALL clear on every entry into 11.
REQ-023 Entry into 11 with any other accumulator value, for example a half turn reversed, SHALL produce no step.
REQ-024 step SHALL be high for exactly one cycle per detent. dir and position SHALL update on the same edge step rises.
REQ-025 dir SHALL hold its value between steps.
REQ-026 position SHALL increment on a clockwise step and decrement on a counter-clockwise step, wrapping 2^POS_WIDTH-1 <-> 0 without saturation.
REQ-027 press_pulse SHALL assert for one cycle, on the edge after the debounced press level rises 0 -> 1. Release SHALL produce no pulse.
REQ-028 Total latency from a stable raw edge to the corresponding pulse SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, constant and documented in the testbench.
REQ-029 Rotation and press paths SHALL be independent; simultaneous events on both SHALL both be reported on their own outputs.

Reset
REQ-030 While rst is high at a clock edge, all state SHALL reset: synchronizers, debounced a/b to 1, debounced press to 0, counters and accumulator to 0, previous pair to 11.
REQ-031 While rst is high, outputs SHALL be step=0, dir=0, position=0, press_pulse=0.
REQ-032 Reset asserted mid-rotation SHALL discard the partial accumulator.
REQ-033 After reset releases, a new step SHALL require a full 4-transition sequence starting from 11.
REQ-034 If the inputs are not at 11 when reset releases, the first entry into 11 SHALL yield no step.

Verification (simulate with DEBOUNCE_CYCLES=4, POS_WIDTH=8)
REQ-035 Clean clockwise detent: from reset, drive {b,a} 11->10->00->01->11, each held 10 cycles. Required: one step pulse, dir=1, position=1.
REQ-036 Counter-clockwise wrap: from position=0, drive one CCW detent 11->01->00->10->11. Required: one step, dir=0, position=255.
REQ-037 Bounce rejection: toggle rot_a for 3-cycle bursts around each true edge of a CW detent. Required: exactly one step, position +1, and no step during the bursts.
REQ-038 Half turn reversed: drive 11->10->00->10->11. Required: no step, and position unchanged.
REQ-039 Illegal jump: drive 11->00->11. Required: no step, and the accumulator cleared, so a following clean CW detent gives exactly one step.
REQ-040 Press and reset: hold rot_press high 20 cycles. Required: one press_pulse, 7 cycles after the rise (latency 2+4+1). Then assert rst after two CW transitions and complete the sequence. Required: no step, and position=0.
